// File: rtl/lif_spike_event_encoder_pkg.sv
// Shared constants, event record type and helpers for the LIF spike event encoder.
package lif_enc_pkg;

  localparam int TS_W       = 8;
  localparam int VM_W       = 7;
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_AW    = $clog2(FIFO_DEPTH);

  localparam logic            BEAT_TS = 1'b0;
  localparam logic            BEAT_PK = 1'b1;
  localparam logic [TS_W-1:0] TS_MAX  = {TS_W{1'b1}};

  typedef struct packed {
    logic [TS_W-1:0] ts;
    logic [VM_W-1:0] peak;
  } lif_event_t;

  function automatic logic [VM_W-1:0] vm_max(input logic [VM_W-1:0] a,
                                             input logic [VM_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lif_spike_event_encoder_fifo.sv
// Small synchronous event FIFO; a push into a full FIFO is accepted when a pop happens on the same edge.
module lif_event_fifo
  import lif_enc_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_flush,
  input  logic       i_push,
  input  logic       i_pop,
  input  lif_event_t i_data,
  output lif_event_t o_head,
  output logic       o_empty,
  output logic       o_full
);

  localparam logic [FIFO_AW:0] PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};

  logic [FIFO_AW:0] r_wptr;
  logic [FIFO_AW:0] r_rptr;
  lif_event_t       r_mem [FIFO_DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  // The extra pointer MSB tells full (MSBs differ) from empty (MSBs equal).
  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[FIFO_AW] != r_rptr[FIFO_AW]) &&
                     (r_wptr[FIFO_AW-1:0] == r_rptr[FIFO_AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_head    = r_mem[r_rptr[FIFO_AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_do_push) begin
      r_mem[r_wptr[FIFO_AW-1:0]] <= i_data;
    end
  end

endmodule

// File: rtl/lif_spike_event_encoder.sv
// LIF spike event encoder: timestamps spikes, tracks the peak membrane potential between spikes,
// buffers events and streams them as two-beat byte packets, and reports a windowed spike rate.
module lif_spike_event_encoder
  import lif_enc_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_ena,
  input  logic            i_params_ready,
  input  logic            i_spike_in,
  input  logic [VM_W-1:0] i_v_mem_in,
  output logic [7:0]      o_ev_data,
  output logic            o_ev_last,
  output logic            o_ev_valid,
  input  logic            i_ev_ready,
  output logic            o_overflow,
  output logic [TS_W-1:0] o_rate_count,
  output logic            o_rate_valid
);

  logic [TS_W-1:0] r_ts;
  logic            r_spike_d;
  logic [VM_W-1:0] r_peak;
  logic            r_beat_sel;
  logic [TS_W-1:0] r_win_cnt;
  logic [TS_W-1:0] r_rate_count;
  logic            r_rate_valid;
  logic            r_overflow;

  logic            w_active;
  logic            w_clear;
  logic            w_event;
  logic            w_wrap;
  logic            w_xfer;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic [VM_W-1:0] w_peak_new;
  logic [TS_W-1:0] w_event_inc;
  lif_event_t      w_entry;
  lif_event_t      w_head;

  assign w_active    = i_ena && i_params_ready;
  assign w_clear     = i_ena && !i_params_ready;
  assign w_event     = w_active && i_spike_in && !r_spike_d;
  assign w_wrap      = (r_ts == TS_MAX);
  assign w_peak_new  = vm_max(r_peak, i_v_mem_in);
  assign w_event_inc = {{(TS_W-1){1'b0}}, w_event};
  assign w_xfer      = w_active && !w_empty && i_ev_ready;
  assign w_pop       = w_xfer && (r_beat_sel == BEAT_PK);
  assign w_entry.ts   = r_ts;
  assign w_entry.peak = w_peak_new;

  lif_event_fifo u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (w_clear),
    .i_push  (w_event),
    .i_pop   (w_pop),
    .i_data  (w_entry),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // Timestamp, spike edge detector and running peak since the last event.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ts      <= '0;
      r_spike_d <= 1'b0;
      r_peak    <= '0;
    end else if (w_clear) begin
      r_ts      <= '0;
      r_spike_d <= 1'b0;
      r_peak    <= '0;
    end else if (w_active) begin
      r_ts      <= r_ts + {{(TS_W-1){1'b0}}, 1'b1};
      r_spike_d <= i_spike_in;
      r_peak    <= w_event ? '0 : w_peak_new;
    end else begin
      r_ts      <= r_ts;
      r_spike_d <= r_spike_d;
      r_peak    <= r_peak;
    end
  end

  // Rate window: a spike on the wrap cycle still belongs to the window being closed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_win_cnt    <= '0;
      r_rate_count <= '0;
      r_rate_valid <= 1'b0;
    end else if (w_clear) begin
      r_win_cnt    <= '0;
      r_rate_count <= r_rate_count;
      r_rate_valid <= 1'b0;
    end else if (w_active && w_wrap) begin
      r_win_cnt    <= '0;
      r_rate_count <= r_win_cnt + w_event_inc;
      r_rate_valid <= 1'b1;
    end else if (w_active) begin
      r_win_cnt    <= r_win_cnt + w_event_inc;
      r_rate_count <= r_rate_count;
      r_rate_valid <= 1'b0;
    end else begin
      r_win_cnt    <= r_win_cnt;
      r_rate_count <= r_rate_count;
      r_rate_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_beat_sel <= BEAT_TS;
      r_overflow <= 1'b0;
    end else if (w_clear) begin
      r_beat_sel <= BEAT_TS;
      r_overflow <= r_overflow;
    end else begin
      r_beat_sel <= w_xfer ? ~r_beat_sel : r_beat_sel;
      r_overflow <= r_overflow || (w_event && w_full && !w_pop);
    end
  end

  // Beat mux straight off the FIFO head so a stalled beat stays stable.
  always_comb begin
    o_ev_data = 8'h00;
    o_ev_last = 1'b0;
    if (w_empty) begin
      o_ev_data = 8'h00;
      o_ev_last = 1'b0;
    end else if (r_beat_sel == BEAT_PK) begin
      o_ev_data = {{(8-VM_W){1'b0}}, w_head.peak};
      o_ev_last = 1'b1;
    end else begin
      o_ev_data = w_head.ts;
      o_ev_last = 1'b0;
    end
  end

  assign o_ev_valid   = !w_empty;
  assign o_overflow   = r_overflow;
  assign o_rate_count = r_rate_count;
  assign o_rate_valid = r_rate_valid;

endmodule

// File: tb/tb_lif_spike_event_encoder.sv
// Self-checking bench: randomized and directed stimulus against a queue-based event model.
module tb_lif_spike_event_encoder;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b0;
  logic       pr = 1'b0;
  logic       spk = 1'b0;
  logic       rdy = 1'b0;
  logic [6:0] vm = 7'h00;
  logic [7:0] ev_data;
  logic       ev_last;
  logic       ev_valid;
  logic       overflow;
  logic [7:0] rate_count;
  logic       rate_valid;

  always #5 clk = ~clk;

  lif_spike_event_encoder dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_ena          (ena),
    .i_params_ready (pr),
    .i_spike_in     (spk),
    .i_v_mem_in     (vm),
    .o_ev_data      (ev_data),
    .o_ev_last      (ev_last),
    .o_ev_valid     (ev_valid),
    .i_ev_ready     (rdy),
    .o_overflow     (overflow),
    .o_rate_count   (rate_count),
    .o_rate_valid   (rate_valid)
  );

  typedef struct {
    int ts;
    int pk;
  } ev_t;

  ev_t q[$];
  int  m_ts, m_peak, m_beat, m_win, m_rate;
  bit  m_spd, m_ovf, m_rv;
  int  checks = 0;
  int  failures = 0;
  bit  chk_on = 1'b0;
  int  log_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    q.delete();
    m_ts = 0; m_peak = 0; m_beat = 0; m_win = 0; m_rate = 0;
    m_spd = 1'b0; m_ovf = 1'b0; m_rv = 1'b0;
  endtask

  // Event-level model: one clock edge, with the inputs that were present at that edge.
  task automatic m_step();
    bit  ev;
    bit  pop;
    int  pk;
    ev_t e;
    m_rv = 1'b0;
    if (!ena) return;
    if (!pr) begin
      m_ts = 0; m_spd = 1'b0; m_peak = 0; m_win = 0; m_beat = 0;
      q.delete();
      return;
    end
    pop = 1'b0;
    if (q.size() > 0 && rdy) begin
      if (m_beat == 1) pop = 1'b1;
      m_beat = 1 - m_beat;
    end
    ev = spk && !m_spd;
    pk = (int'(vm) > m_peak) ? int'(vm) : m_peak;
    if (pop) void'(q.pop_front());
    if (ev) begin
      if (q.size() < DEPTH) begin
        e.ts = m_ts;
        e.pk = pk;
        q.push_back(e);
      end else begin
        m_ovf = 1'b1;
      end
    end
    m_peak = ev ? 0 : pk;
    if (m_ts == 255) begin
      m_rate = m_win + int'(ev);
      m_rv   = 1'b1;
      m_win  = 0;
    end else begin
      m_win = m_win + int'(ev);
    end
    m_ts  = (m_ts + 1) % 256;
    m_spd = spk;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) m_reset();
    else m_step();
    #2;
  endtask

  // Compare process: every output against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("ev_valid", ev_valid, (q.size() > 0));
      if (q.size() > 0) check("ev_data", ev_data, (m_beat == 1) ? q[0].pk : q[0].ts);
      check("ev_last", ev_last, (q.size() > 0 && m_beat == 1));
      check("overflow", overflow, m_ovf);
      check("rate_count", rate_count, m_rate);
      check("rate_valid", rate_valid, m_rv);
    end
  end

  task automatic check_zero(input string pfx);
    check({pfx, "_valid"}, ev_valid, 0);
    check({pfx, "_data"}, ev_data, 0);
    check({pfx, "_last"}, ev_last, 0);
    check({pfx, "_ovf"}, overflow, 0);
    check({pfx, "_rate"}, rate_count, 0);
    check({pfx, "_rv"}, rate_valid, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_reset();
    ena = 1'b1; pr = 1'b1; spk = 1'b0; vm = 7'h00; rdy = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Accept beats with ready high until the stream empties, logging each beat.
  task automatic drain();
    rdy = 1'b1;
    spk = 1'b0;
    log_q.delete();
    for (int k = 0; k < 40 && ev_valid; k++) begin
      log_q.push_back(int'(ev_data));
      tick();
    end
    check("drain_done", ev_valid, 0);
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      ena = ($urandom_range(0, 19) != 0);
      pr  = ($urandom_range(0, 999) != 0);
      spk = ($urandom_range(0, 2) == 0);
      vm  = 7'($urandom_range(0, 127));
      rdy = ($urandom_range(0, 9) < 6);
      tick();
    end
  endtask

  initial begin
    int pulses;
    int exp3[8];
    exp3 = '{0, 1, 2, 2, 4, 3, 6, 4};
    m_reset();
    #1 rst_n = 1'b0;
    #2;
    chk_on = 1'b1;
    check_zero("rst");

    // Single spike at ts=0x12 with a peak of 0x3F earlier in the interval.
    do_reset();
    rdy = 1'b1;
    for (int i = 0; i < 18; i++) begin
      vm = (i == 5) ? 7'h3F : 7'($urandom_range(0, 62));
      tick();
    end
    spk = 1'b1; vm = 7'h10;
    tick();
    check("t2_valid", ev_valid, 1);
    check("t2_beat0", ev_data, 8'h12);
    check("t2_last0", ev_last, 0);
    spk = 1'b0; vm = 7'h00;
    tick();
    check("t2_beat1", ev_data, 8'h3F);
    check("t2_last1", ev_last, 1);
    tick();
    check("t2_empty", ev_valid, 0);

    // Full FIFO: beat1 accepted on the same edge as a new spike.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      spk = 1'b1; vm = 7'($urandom_range(0, 127)); tick();
      spk = 1'b0; tick();
    end
    check("t4_valid", ev_valid, 1);
    check("t4_ovf_before", overflow, 0);
    rdy = 1'b1;
    tick();
    spk = 1'b1;
    tick();
    check("t4_ovf_after", overflow, 0);
    drain();
    check("t4_beats", log_q.size(), 8);

    // Five spikes with ready low: four kept in order, fifth dropped.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      spk = 1'b1; vm = 7'(i + 1); tick();
      spk = 1'b0; vm = 7'h00; tick();
    end
    check("t3_ovf", overflow, 1);
    drain();
    check("t3_beats", log_q.size(), 8);
    for (int k = 0; k < 8; k++) begin
      if (k < log_q.size()) check($sformatf("t3_byte%0d", k), log_q[k], exp3[k]);
    end
    check("t3_ovf_kept", overflow, 1);

    // Rate window: three spikes, then one spike plus one on the wrap cycle.
    do_reset();
    rdy = 1'b1;
    pulses = 0;
    for (int e = 0; e < 256; e++) begin
      spk = (e == 10 || e == 20 || e == 30);
      vm  = 7'($urandom_range(0, 127));
      tick();
      if (e < 255) pulses += int'(rate_valid);
    end
    check("t5_rv", rate_valid, 1);
    check("t5_rate", rate_count, 3);
    check("t5_no_early", pulses, 0);
    pulses = 0;
    for (int e = 256; e < 512; e++) begin
      spk = (e == 300 || e == 511);
      tick();
      pulses += int'(rate_valid);
    end
    check("t5_rate_wrap_spike", rate_count, 2);
    check("t5_pulses", pulses, 1);
    spk = 1'b0;
    tick();
    check("t5_rv_drop", rate_valid, 0);
    drain();

    // Configuration drop between beat0 and beat1 with spike_in held high.
    rdy = 1'b0; spk = 1'b1;
    tick();
    rdy = 1'b1;
    tick();
    check("t6_mid", ev_last, 1);
    pr = 1'b0;
    tick();
    check("t6_valid", ev_valid, 0);
    check("t6_rate", rate_count, 2);
    pr = 1'b1;
    tick();
    check("t6_reevent_valid", ev_valid, 1);
    check("t6_reevent_ts", ev_data, 8'h00);
    drain();

    rand_cycles(1500);

    // Asynchronous reset in the middle of traffic.
    ena = 1'b1; pr = 1'b1; rdy = 1'b0;
    spk = 1'b1; tick(); spk = 1'b0; tick();
    rst_n = 1'b0;
    m_reset();
    #1;
    check_zero("midrst");
    tick();
    rst_n = 1'b1;
    spk = 1'b1;
    tick();
    check("t1_valid", ev_valid, 1);
    check("t1_ts0", ev_data, 8'h00);

    rand_cycles(1500);

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
